// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared 32-bit ALU: grants one requester, registers its operands,
// captures result and opcode-masked flags. Define ALU_ARB_FIXED_PRIO_EN for port-0-wins tie-break.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OPC_W-1:0]  req0_aluc,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OPC_W-1:0]  req1_aluc,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_r,
  output logic [3:0]        rsp_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OPC_W-1:0]  alu_aluc,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [OPC_W-1:0]    op_aluc;
  logic                op_owner;
  logic [DATA_W-1:0]   rsp_q;
  logic [3:0]          flags_q;
  logic                rsp_owner;
  logic                last_grant;
  logic                arb_en, tie_to0, grant0, grant1, grant_any;
  logic                carry_en, ovf_en;

  // Grants are combinational and only offered outside EXEC; reset also blocks them.
  always_comb begin
    arb_en = rst_n && (state != EXEC);
`ifdef ALU_ARB_FIXED_PRIO_EN
    tie_to0 = 1'b1 | last_grant;
`else
    tie_to0 = last_grant;
`endif
    grant0    = arb_en && req0_valid && (!req1_valid || tie_to0);
    grant1    = arb_en && req1_valid && !grant0;
    grant_any = grant0 || grant1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = grant_any ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Carry and overflow are only meaningful for some opcodes; others are forced to 0.
  always_comb begin
    carry_en = op_aluc inside {OPC_W'(0), OPC_W'(1), OPC_W'(12), OPC_W'(13), OPC_W'(14), OPC_W'(15)};
    ovf_en   = op_aluc inside {OPC_W'(2), OPC_W'(3)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_aluc    <= '0;
      op_owner   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        op_a       <= grant1 ? req1_a    : req0_a;
        op_b       <= grant1 ? req1_b    : req0_b;
        op_aluc    <= grant1 ? req1_aluc : req0_aluc;
        op_owner   <= grant1;
        last_grant <= grant1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q     <= '0;
      flags_q   <= '0;
      rsp_owner <= 1'b0;
    end else if (state == EXEC) begin
      rsp_q     <= alu_r;
      flags_q   <= {alu_overflow & ovf_en, alu_negative, alu_carry & carry_en, alu_zero};
      rsp_owner <= op_owner;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state == RESP) && !rsp_owner;
  assign rsp1_valid = (state == RESP) && rsp_owner;
  assign rsp_r      = rsp_q;
  assign rsp_flags  = flags_q;
  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign alu_aluc   = op_aluc;
  assign busy       = (state == EXEC);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU between two requesters: port 0, the execute stage, and port 1, the branch/address unit. It arbitrates between them, registers the winning operands into the ALU, and captures the result plus a masked flag set into a response register. The response is returned to the granted requester with a one-cycle valid pulse. The block sits between the requesters and the ALU instance; the requesters never drive the ALU directly.

## Interface
Parameters:
- DATA_W, 32: operand and result width; fixed to the ALU width.
- OPC_W, 4: width of the ALU opcode (`aluc`).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has an operation pending; held until its ready.
- req0_ready / req1_ready  out  1  grant; the operation is accepted in the cycle where valid && ready.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- req0_aluc / req1_aluc  in  OPC_W  ALU opcode.
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse; the response belongs to that port.
- rsp_r  out  DATA_W  result.
- rsp_flags  out  4  bit order {overflow, negative, carry, zero}.
- alu_a, alu_b  out  DATA_W  ALU operands, driven from the operand register.
- alu_aluc  out  OPC_W  ALU opcode, driven from the operand register.
- alu_r  in  DATA_W  ALU result.
- alu_zero, alu_carry, alu_negative, alu_overflow  in  1  ALU flags.
- busy  out  1  high when the state is EXEC.

## Operation
State machine: IDLE, EXEC, RESP.

IDLE
- If either valid is high, arbitrate and assert the winner's ready combinationally.
- Latch a, b, aluc and the owner ID into the operand register.
- Go to EXEC.

EXEC
- The operand register drives the ALU.
- At the clock edge, capture alu_r and the masked flags into the response register with its owner ID.
- Go to RESP.

RESP
- Assert rsp<owner>_valid for exactly one cycle. There is no backpressure: the requester must accept it.
- Arbitrate in the same cycle. If a valid is present, grant it and go to EXEC. Otherwise go to IDLE.

Arbitration
- Only one ready is high at a time, and never in EXEC.
- A single valid is granted.
- When both are valid, the grant goes to the port not granted last (`last_grant` register).
- `last_grant` resets to 1, so port 0 wins the first tie.

Flag masking (applied at capture)
- zero, negative: always captured.
- carry: captured only for aluc 0000, 0001, 1100, 1101, 1110, 1111; forced to 0 otherwise.
- overflow: captured only for aluc 0010, 0011; forced to 0 otherwise.
- This removes dependence on ALU flag values that the opcode does not define.

Response register
- rsp_r and rsp_flags hold their value until the next capture.
- rsp_r and rsp_flags are valid only when qualified by rspN_valid.

## Timing
- Reset values: state = IDLE, all ready = 0, rsp0_valid = rsp1_valid = 0, rsp_r = 0, rsp_flags = 0, alu_a = alu_b = 0, alu_aluc = 0, busy = 0, last_grant = 1.
- Latency: acceptance in cycle N gives rspN_valid in cycle N+2.
- Throughput: one operation per 2 cycles when requests are back-to-back.
- In RESP, the old response and the new grant coincide; this is legal even when both are the same port.
- A requester dropping valid before its ready is illegal; the controller's behaviour in that case is undefined.
- Reset asserted mid-operation: clear immediately to reset values. The in-flight operation is dropped and no response is issued.
- First acceptance after reset release: the first rising edge where rst_n is high and a valid is present.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins ties. last_grant is still maintained but ignored.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin tie-break as described above.

## Test plan
- Reset, then port 0 requests a=5, b=3, aluc=0001 → req0_ready in cycle 0; rsp0_valid in cycle 2; rsp_r=2; flags {ovf 0, neg 0, carry 0, zero 0}.
- Both ports valid continuously. Port 0: add 1+1 (0000). Port 1: slt a=-1, b=0 (1011). → Grants alternate 0,1,0,1 with a grant every 2 cycles. Port 0 responses: r=2. Port 1 responses: r=1, neg 1, carry 0, ovf 0.
- Port 1: a=0x7FFFFFFF, b=1, aluc=0010 → rsp1_valid; r=0x80000000; overflow 1, negative 1, carry 0 (masked).
- Port 0: aluc=0100, a=0xF0, b=0x0F while the ALU carry input is forced to 1 → r=0; zero 1; carry 0; overflow 0.
- rst_n pulsed low in EXEC → no rsp pulse ever; all outputs at reset values while low; the next request is served normally.
- With ALU_ARB_FIXED_PRIO_EN defined and both ports valid for 6 cycles → only port 0 is granted (3 grants); port 1 is never granted.
